// File: rtl/prio_irq_encoder.sv
`default_nettype none
// ============================================================================
// prio_irq_encoder : sticky, maskable request capture with fixed or
//                    round-robin priority selection and a valid/ready output.
// Revision 1.0
// ============================================================================
module prio_irq_encoder #(
    parameter int N       = 8,
    parameter int W       = $clog2(N),
    parameter bit RR_MODE = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    output logic [W-1:0] idx,
    output logic         valid,
    input  logic         ready,
    output logic [N-1:0] pending,
    output logic         any_pending
);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_PRESENT = 1'b1;

    logic [0:0]   state_q, state_d;
    logic [N-1:0] pending_q, pending_d;
    logic [W-1:0] idx_q, idx_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic [W-1:0] sel;
    logic [N-1:0] clr;
    logic         accept;
    logic         found;
    int           cand;
    logic [W-1:0] cand_w;

    assign accept = (state_q == S_PRESENT) && ready;
    assign clr    = accept ? ({{(N-1){1'b0}}, 1'b1} << idx_q) : '0;

    // Set wins over clear so a request still high in its accept cycle re-pends.
    assign pending_d = (pending_q & ~clr) | (req & mask);
    assign ptr_d     = !accept ? ptr_q : ((idx_q == '0) ? W'(N - 1) : idx_q - 1'b1);

    always_comb begin
        sel    = '0;
        found  = 1'b0;
        cand   = 0;
        cand_w = '0;
        if (RR_MODE) begin
            // Walk downward from ptr with wrap; the first pending bit wins.
            for (int i = 0; i < N; i++) begin
                cand = int'(ptr_q) - i;
                if (cand < 0) begin
                    cand = cand + N;
                end
                cand_w = W'(cand);
                if (!found && pending_q[cand_w]) begin
                    found = 1'b1;
                    sel   = cand_w;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (pending_q[i]) begin
                    sel = W'(i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            idx_q     <= '0;
            ptr_q     <= W'(N - 1);
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (pending_q != '0) begin
                    idx_d   = sel;
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        valid       = (state_q == S_PRESENT);
        idx         = idx_q;
        pending     = pending_q;
        any_pending = |pending_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_prio_irq_encoder.sv
`default_nettype none
// Bench for prio_irq_encoder: fixed and round-robin instances side by side,
// directed scenarios plus randomized traffic against a transaction-level model.
module tb_prio_irq_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ready;

    logic [2:0] f_idx, r_idx;
    logic       f_valid, r_valid;
    logic [7:0] f_pend, r_pend;
    logic       f_any, r_any;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: index 0 = fixed instance, 1 = round-robin instance.
    logic [7:0] m_pend [2];
    bit         m_valid[2];
    int         m_idx  [2];
    int         m_ptr  [2];

    always #5 clk = ~clk;

    prio_irq_encoder #(.N(8), .RR_MODE(1'b0)) u_fix (
        .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .idx(f_idx),
        .valid(f_valid), .ready(ready), .pending(f_pend), .any_pending(f_any)
    );

    prio_irq_encoder #(.N(8), .RR_MODE(1'b1)) u_rr (
        .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .idx(r_idx),
        .valid(r_valid), .ready(ready), .pending(r_pend), .any_pending(r_any)
    );

    // idx only matters while valid, so it is folded to zero otherwise.
    wire [12:0] f_obs = {f_valid, (f_valid ? f_idx : 3'd0), f_pend, f_any};
    wire [12:0] r_obs = {r_valid, (r_valid ? r_idx : 3'd0), r_pend, r_any};

    function automatic int pick(input int mode, input logic [7:0] p, input int ptr);
        int j;
        if (mode == 0) begin
            for (int i = 7; i >= 0; i--) if (p[i]) return i;
        end else begin
            for (int k = 0; k < 8; k++) begin
                j = (ptr - k + 8) % 8;
                if (p[j]) return j;
            end
        end
        return 0;
    endfunction

    function automatic logic [12:0] model_obs(input int m);
        logic [2:0] mi;
        mi = m_valid[m] ? 3'(m_idx[m]) : 3'd0;
        return {m_valid[m], mi, m_pend[m], |m_pend[m]};
    endfunction

    task automatic cycle();
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            logic [7:0] np;
            bit         acc;
            if (!rst_n) begin
                m_pend[m]  = 8'h00;
                m_valid[m] = 1'b0;
                m_idx[m]   = 0;
                m_ptr[m]   = 7;
            end else begin
                acc = m_valid[m] && ready;
                np  = m_pend[m];
                if (acc) np[m_idx[m]] = 1'b0;
                np = np | (req & mask);
                if (acc) begin
                    m_valid[m] = 1'b0;
                    m_ptr[m]   = (m_idx[m] + 7) % 8;
                end else if (!m_valid[m] && m_pend[m] != 8'h00) begin
                    m_valid[m] = 1'b1;
                    m_idx[m]   = pick(m, m_pend[m], m_ptr[m]);
                end
                m_pend[m] = np;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 8'hFF; mask = 8'hFF; ready = 1'b0;
        cycle(); cycle();
        vectors++;
        if ({f_valid, f_idx, f_pend} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_fix: got valid/idx/pend=%h want 000", {f_valid, f_idx, f_pend});
        end
        vectors++;
        if ({r_valid, r_idx, r_pend} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_rr: got valid/idx/pend=%h want 000", {r_valid, r_idx, r_pend});
        end
        rst_n = 1'b1; req = 8'h00;
        cycle(); cycle();
        vectors++;
        if ({f_valid, f_idx, f_pend, f_any} !== 13'h0) begin
            miscompares++;
            $display("FAIL reset_release: got %h want 0", {f_valid, f_idx, f_pend, f_any});
        end
    endtask

    task automatic test_fixed();
        logic [12:0] exp_seq [6];
        exp_seq = '{ {1'b0, 3'd0, 8'h14, 1'b1}, {1'b1, 3'd4, 8'h14, 1'b1},
                     {1'b0, 3'd0, 8'h04, 1'b1}, {1'b1, 3'd2, 8'h04, 1'b1},
                     {1'b0, 3'd0, 8'h00, 1'b0}, {1'b0, 3'd0, 8'h00, 1'b0} };
        mask = 8'hFF; ready = 1'b1; req = 8'h14;
        for (int c = 0; c < 6; c++) begin
            cycle();
            req = 8'h00;
            vectors++;
            if (f_obs !== exp_seq[c]) begin
                miscompares++;
                $display("FAIL fixed_c%0d: got %h want %h", c, f_obs, exp_seq[c]);
            end
            vectors++;
            if (r_obs !== exp_seq[c]) begin
                miscompares++;
                $display("FAIL fixed_rr_c%0d: got %h want %h", c, r_obs, exp_seq[c]);
            end
        end
    endtask

    task automatic test_hold();
        logic [12:0] exp_seq [7];
        logic [7:0]  req_seq [7];
        logic        rdy_seq [7];
        exp_seq = '{ {1'b0, 3'd0, 8'h04, 1'b1}, {1'b1, 3'd2, 8'h04, 1'b1},
                     {1'b1, 3'd2, 8'h84, 1'b1}, {1'b1, 3'd2, 8'h84, 1'b1},
                     {1'b0, 3'd0, 8'h80, 1'b1}, {1'b1, 3'd7, 8'h80, 1'b1},
                     {1'b0, 3'd0, 8'h00, 1'b0} };
        req_seq = '{8'h04, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00};
        rdy_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int c = 0; c < 7; c++) begin
            req = req_seq[c]; ready = rdy_seq[c];
            cycle();
            vectors++;
            if (f_obs !== exp_seq[c]) begin
                miscompares++;
                $display("FAIL hold_c%0d: got %h want %h", c, f_obs, exp_seq[c]);
            end
            vectors++;
            if (r_obs !== exp_seq[c]) begin
                miscompares++;
                $display("FAIL hold_rr_c%0d: got %h want %h", c, r_obs, exp_seq[c]);
            end
        end
    endtask

    task automatic test_mask();
        logic [12:0] exp_seq [6];
        logic [7:0]  req_seq [6];
        exp_seq = '{ 13'h0, 13'h0, 13'h0, {1'b0, 3'd0, 8'h01, 1'b1},
                     {1'b1, 3'd0, 8'h01, 1'b1}, 13'h0 };
        req_seq = '{8'h80, 8'h80, 8'h80, 8'h81, 8'h00, 8'h00};
        mask = 8'h7F; ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            req = req_seq[c];
            cycle();
            vectors++;
            if (f_obs !== exp_seq[c]) begin
                miscompares++;
                $display("FAIL mask_c%0d: got %h want %h", c, f_obs, exp_seq[c]);
            end
        end
        mask = 8'hFF;
    endtask

    task automatic test_rr();
        int exp_g;
        rst_n = 1'b0; req = 8'h00;
        cycle();
        rst_n = 1'b1; mask = 8'hFF; req = 8'hFF; ready = 1'b1;
        cycle(); cycle();
        for (int g = 0; g < 9; g++) begin
            exp_g = (7 - g + 8) % 8;
            vectors++;
            if (r_obs !== {1'b1, 3'(exp_g), 8'hFF, 1'b1}) begin
                miscompares++;
                $display("FAIL rr_grant%0d: got %h want %h", g, r_obs, {1'b1, 3'(exp_g), 8'hFF, 1'b1});
            end
            vectors++;
            if (f_obs !== {1'b1, 3'd7, 8'hFF, 1'b1}) begin
                miscompares++;
                $display("FAIL rr_fixed_grant%0d: got %h want %h", g, f_obs, {1'b1, 3'd7, 8'hFF, 1'b1});
            end
            cycle();
            vectors++;
            if (r_obs !== {1'b0, 3'd0, 8'hFF, 1'b1}) begin
                miscompares++;
                $display("FAIL rr_bubble%0d: got %h want %h", g, r_obs, {1'b0, 3'd0, 8'hFF, 1'b1});
            end
            cycle();
        end
        req = 8'h00;
        repeat (20) cycle();
        vectors++;
        if ({f_pend, r_pend, f_valid, r_valid} !== 18'h0) begin
            miscompares++;
            $display("FAIL rr_drain: got %h want 0", {f_pend, r_pend, f_valid, r_valid});
        end
    endtask

    task automatic test_reset_mid();
        ready = 1'b1; req = 8'h20;
        cycle();
        req = 8'h00;
        cycle(); cycle();
        ready = 1'b0; req = 8'h20;
        cycle();
        req = 8'h00;
        cycle();
        vectors++;
        if ({f_obs, r_obs} !== {2{1'b1, 3'd5, 8'h20, 1'b1}}) begin
            miscompares++;
            $display("FAIL rstmid_present: got %h want %h", {f_obs, r_obs}, {2{1'b1, 3'd5, 8'h20, 1'b1}});
        end
        ready = 1'b1; rst_n = 1'b0;
        cycle();
        vectors++;
        if ({f_valid, f_idx, f_pend, r_valid, r_idx, r_pend} !== 24'h0) begin
            miscompares++;
            $display("FAIL rstmid_reset: got %h want 0", {f_valid, f_idx, f_pend, r_valid, r_idx, r_pend});
        end
        rst_n = 1'b1; req = 8'hFF;
        cycle(); cycle();
        vectors++;
        if ({f_obs, r_obs} !== {2{1'b1, 3'd7, 8'hFF, 1'b1}}) begin
            miscompares++;
            $display("FAIL rstmid_first_grant: got %h want %h", {f_obs, r_obs}, {2{1'b1, 3'd7, 8'hFF, 1'b1}});
        end
        req = 8'h00;
        repeat (20) cycle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            req   = 8'($urandom) & 8'($urandom) & 8'($urandom);
            mask  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            ready = ($urandom_range(0, 2) != 0);
            cycle();
            vectors++;
            if (f_obs !== model_obs(0)) begin
                miscompares++;
                $display("FAIL rand_fix_c%0d: got %h want %h", c, f_obs, model_obs(0));
            end
            vectors++;
            if (r_obs !== model_obs(1)) begin
                miscompares++;
                $display("FAIL rand_rr_c%0d: got %h want %h", c, r_obs, model_obs(1));
            end
        end
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            m_pend[m] = 8'h00; m_valid[m] = 1'b0; m_idx[m] = 0; m_ptr[m] = 7;
        end
        test_reset();
        test_fixed();
        test_hold();
        test_mask();
        test_rr();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prio_irq_encoder.md
Name: prio_irq_encoder

Overview:
- Parametrised, registered successor to the 8-to-3 combinational priority encoder.
- Captures N level request lines into a sticky, maskable pending register.
- Selects one pending index by fixed (highest index wins) or round-robin priority, and presents it on a valid/ready handshake.
- An accepted index clears its pending bit; the block sits between raw request sources and a single serialising consumer (interrupt/service dispatcher).

Parameters:
- N, 8, number of request lines (2..64).
- W, $clog2(N), width of index output.
- RR_MODE, 0, 0 = fixed priority (bit N-1 highest), 1 = round-robin.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on clk rising edge.
- req  input  N  level request lines.
- mask  input  N  1 = request enabled; masked bits are never captured.
- idx  output  W  selected request index; meaningful only while valid=1.
- valid  output  1  idx is being presented.
- ready  input  1  consumer accepts idx when valid&&ready on a clk edge.
- pending  output  N  current sticky pending register.
- any_pending  output  1  OR-reduction of pending (registered value, not req).

Behaviour:
- Reset (rst_n=0 at a clk edge): pending=0, idx=0, valid=0, state=IDLE, rr pointer=N-1. Takes priority over all other events, including a handshake in the same cycle.
- Pending update every edge: pending_next = (pending & ~clr) | (req & mask).
  - clr is the one-hot of idx when valid&&ready, else 0.
  - Set wins over clear: a bit still requested in its accept cycle re-pends.
  - Mask gates capture only; already-pending bits stay pending when masked later.
- FSM, two states:
  - IDLE: valid=0. If pending!=0, register idx=select(pending), go PRESENT. Else stay.
  - PRESENT: valid=1, idx held stable. On valid&&ready: clear that pending bit, go IDLE. Otherwise idx must not change, even if higher-priority requests arrive or mask changes.
- Latency:
  - req high in cycle t → pending bit visible t+1 → valid=1 with idx at t+2.
  - After accept at edge t, valid=0 in cycle t+1 (one mandatory bubble). The earliest next valid is t+2.
- Selection:
  - Fixed mode: highest set index of pending.
  - RR mode: search from ptr downward with wrap (ptr, ptr-1, ..., 0, N-1, ..., ptr+1); first set bit wins.
  - On accept of index g, ptr = (g==0) ? N-1 : g-1, so g becomes lowest priority. ptr only updates on accept.
  - In fixed mode ptr is unused.
- Width: idx is zero-extended into W bits. Non-power-of-two N is legal; indices ≥N are never produced.
- any_pending reflects the pending register, so it is 1 during PRESENT even when no req is currently high.

Test Plan:
- Reset: apply rst_n=0 with req=8'hFF, mask=8'hFF for 2 cycles → pending=0, valid=0, idx=0. Release with req=0 → outputs stay 0.
- Fixed priority (RR_MODE=0): mask=8'hFF, req=8'b0001_0100 for one cycle, then 0. With ready=1:
  - valid rises 2 cycles later with idx=4; accept.
  - Bubble cycle, then idx=2; accept.
  - Then valid=0 and pending=0.
- Hold stability: valid=1, idx=2, ready=0. Pulse req[7] → idx stays 2 and pending=8'b1000_0100. Assert ready → next grant is idx=7.
- Masking: mask=8'b0111_1111, req=8'h80 → pending stays 0, valid never rises. Then req=8'h81 → idx=0 only.
- Round-robin (RR_MODE=1): req=8'hFF held, ready=1 → grants 7,6,5,...,0,7 in order, each separated by one bubble. Set-wins re-pend keeps pending=8'hFF.
- Reset mid-operation: rst_n=0 while valid=1, idx=5, ready=1 → next cycle valid=0, pending=0. In RR mode ptr=N-1, so the first grant after release with req=8'hFF is 7.
